mult_share_ctrl: RTL
====================

Name: mult_share_ctrl

Overview:
- Controller that shares one registered signed multiplier (simpleMultiplier-style: en, a, b, 2*WIDTH result) among NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Each in-flight operation is tagged with its requester ID.
- Results are returned through a response FIFO with backpressure; a credit count ensures no result is ever dropped.
- Sits between the execution units and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; product is 2*WIDTH
- MULT_LATENCY, 1, cycles from mult_en/operands presented to mult_result valid (1 for simpleMultiplier)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= MULT_LATENCY+1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B
- mult_en  out  1  multiplier enable
- mult_a  out  WIDTH  multiplier operand A
- mult_b  out  WIDTH  multiplier operand B
- mult_result  in  2*WIDTH  multiplier signed product
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  2*WIDTH  signed product
- resp_id  out  $clog2(NUM_REQ)  originating requester
- busy  out  1  any operation outstanding

Behaviour:
- Reset (synchronous): clears the RR pointer to 0, the operand register, the tag pipeline, the FIFO and the outstanding count.
  - Outputs while reset is high and in the cycle after: req_ready=0, mult_en=0, mult_a=mult_b=0, resp_valid=0, resp_data=0, resp_id=0, busy=0.
- Reset mid-operation: all in-flight operations and queued results are discarded; no resp_valid is produced for them.
- outstanding = operand register occupied + tag pipeline entries + FIFO entries.
  - A dequeue in the current cycle does not free a credit until the next cycle (no bypass).
- Grant (combinational):
  - A grant is possible when reset=0, outstanding < FIFO_DEPTH and any req_valid is high.
  - The granted requester is the first valid index at or after ptr, searching upward with wrap.
  - req_ready is one-hot for the granted index, otherwise all zero.
  - req_ready never depends on the requester's own req_valid being low.
- Transfer occurs when req_valid[i]&req_ready[i]. On transfer (cycle k):
  - ptr <= (grant+1) mod NUM_REQ; ptr is unchanged when there is no transfer.
  - The operand register captures req_a/req_b slices and the ID.
- Issue: in cycle k+1, mult_a/mult_b present the captured operands and a tag enters the pipeline.
- Pipeline: the valid+ID tag shift register has length MULT_LATENCY.
  - In cycle k+1+MULT_LATENCY, mult_result is written to the FIFO with its ID.
- Latency: resp_valid is first high in cycle k+2+MULT_LATENCY (cycle k+3 for the default).
- Throughput: one acceptance per cycle while credit is available.
- mult_en is high in any cycle where the operand register or the tag pipeline holds a valid entry, otherwise 0.
- mult_a/mult_b hold their last value while no new operand is issued.
- Arithmetic: operands and result are two's-complement signed and passed through unmodified; the controller performs no arithmetic on data.
- FIFO:
  - resp_valid = not empty.
  - A pop occurs on resp_valid&resp_ready.
  - A simultaneous push and pop both take effect and the count is unchanged.
  - The credit scheme guarantees a push never occurs while full. An internal assertion flags overflow.
- Ordering: responses are delivered in global acceptance order.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants between its own grants, given credit is available.
- busy = (outstanding != 0).

Test Plan:
1. req0 only, a=553524, b=840, resp_ready=1, accepted cycle 0 -> mult_en high cycle 1; resp_valid cycle 3 with resp_data=464960160, resp_id=0; busy low cycle 4.
2. All four req_valid held high with distinct operands, resp_ready=1 -> req_ready grants 0,1,2,3,0,1,… one per cycle; resp_id sequence 0,1,2,3,… with matching products.
3. Signed operands:
   - req2 a=-259, b=-259 -> resp_data=67081, resp_id=2.
   - req1 a=553524, b=-259 -> resp_data=-143362716 (sign-extended 64-bit).
   - req3 a=-1199060305, b=1 -> -1199060305.
   - req0 a=0, b=1348760118 -> 0.
4. Backpressure: resp_ready=0, req0 valid continuously -> exactly 4 transfers, then req_ready=0. Raise resp_ready at cycle t -> first pop at t, next acceptance at t+1; responses drain in order with none lost.
5. Reset mid-operation: two operations accepted, reset high 1 cycle while results are in flight -> no resp_valid after reset; mult_en=0; next grant goes to requester 0 (ptr reset).
6. Priority rotation: ptr=2 after a grant to 1, with req0 and req3 valid -> grant 3 first, then 0.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin front end that shares one registered signed multiplier among NUM_REQ
// requesters, tags each operation with its requester ID and returns results through a credit-protected FIFO.
module mult_share_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       mult_en,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [2*WIDTH-1:0]         resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int OW  = $clog2(FIFO_DEPTH + MULT_LATENCY + 1) + 1;

  logic [IDW-1:0]            ptr;
  logic                      rst_q;
  logic                      gnt_ok, can_grant, xfer;
  logic [IDW-1:0]            gnt_idx, idx;
  logic [OW-1:0]             outstanding;

  logic                      vld_p0;
  logic signed [WIDTH-1:0]   a_p0, b_p0;
  logic [IDW-1:0]            id_p0;
  logic [MULT_LATENCY-1:0]   vld_p1;
  logic [IDW-1:0]            id_p1 [MULT_LATENCY];

  logic signed [2*WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [IDW-1:0]            fifo_id [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             cnt;
  logic                      push, pop, empty, full;

  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_ok && req_valid[idx]) begin
        gnt_ok  = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Credits: every operation from acceptance until its FIFO slot is popped.
  always_comb begin
    outstanding = OW'(vld_p0) + OW'(cnt);
    for (int i = 0; i < MULT_LATENCY; i++) begin
      outstanding = outstanding + OW'(vld_p1[i]);
    end
  end

  assign can_grant = !reset && !rst_q && (outstanding < OW'(FIFO_DEPTH));
  assign xfer      = can_grant && gnt_ok;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign push  = vld_p1[MULT_LATENCY-1];
  assign pop   = !empty && resp_ready;

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      ptr    <= '0;
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      vld_p1 <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // p0: operand register captured on transfer
      if (xfer) begin
        ptr  <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        a_p0 <= req_a[gnt_idx*WIDTH +: WIDTH];
        b_p0 <= req_b[gnt_idx*WIDTH +: WIDTH];
      end
      vld_p0 <= xfer;
      // p1: tag pipeline tracks the multiplier's latency
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
      end
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) id_p0 <= gnt_idx;
    id_p1[0] <= id_p0;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      id_p1[i] <= id_p1[i-1];
    end
    if (push && !reset) begin
      fifo_data[wr_ptr] <= mult_result;
      fifo_id[wr_ptr]   <= id_p1[MULT_LATENCY-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

  assign mult_en    = !reset && (vld_p0 || (|vld_p1));
  assign mult_a     = reset ? '0 : a_p0;
  assign mult_b     = reset ? '0 : b_p0;
  assign resp_valid = !reset && !empty;
  assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
  assign resp_id    = resp_valid ? fifo_id[rd_ptr] : '0;
  assign busy       = !reset && (outstanding != '0);
endmodule
